// File: rtl/sll_iter.sv
// -----------------------------------------------------------------------------
// sll_iter -- iterative logical shift-left unit for the ALU32 datapath.
//
// A latched operand is shifted left by one bit per clock under a small
// three-state FSM (IDLE -> SHIFT -> FIN -> IDLE).  The result is published on
// Y at the completion edge and announced with a one-cycle DONE pulse.  A zero
// shift count skips SHIFT and completes on the accepting edge.
//
// Ports:
//   CLK        in   1  clock; all state changes on the rising edge
//   RST        in   1  synchronous, active-high reset (priority over START)
//   START      in   1  request; sampled only while IDLE, never queued
//   A          in   N  operand, captured on the accepted START edge
//   SHIFT_AMT  in   M  unsigned shift count, captured with A
//   BUSY       out  1  high while shifting
//   DONE       out  1  one-cycle pulse, Y newly updated
//   Y          out  N  registered result; holds until next completion/reset
// -----------------------------------------------------------------------------
module sll_iter #(
   parameter int N = 32,
   parameter int M = 5
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         START,
   input  logic [N-1:0] A,
   input  logic [M-1:0] SHIFT_AMT,
   output logic         BUSY,
   output logic         DONE,
   output logic [N-1:0] Y
);

   // Encoding chosen so BUSY and DONE each map onto one state bit.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      FIN   = 2'b10
   } state_t;

   localparam logic [M-1:0] cnt_zero = {M{1'b0}};
   localparam logic [M-1:0] cnt_one  = {{(M-1){1'b0}}, 1'b1};

   state_t         state_r;
   state_t         state_s;
   logic [N-1:0]   w_r;
   logic [N-1:0]   w_s;
   logic [M-1:0]   cnt_r;
   logic [M-1:0]   cnt_s;
   logic [N-1:0]   y_r;
   logic [N-1:0]   y_s;
   logic [N-1:0]   w_shl_s;

   // One-bit logical left shift of the work register (MSB drops, LSB zero).
   always_comb begin
      w_shl_s = w_r << 1;
   end

   // Next-state and datapath update logic for the shift FSM.
   always_comb begin
      state_s = state_r;
      w_s     = w_r;
      cnt_s   = cnt_r;
      y_s     = y_r;
      case (state_r)
         IDLE: begin
            if (START) begin
               w_s   = A;
               cnt_s = SHIFT_AMT;
               if (SHIFT_AMT != cnt_zero) begin
                  state_s = SHIFT;
               end else begin
                  // Zero shift: the operand is already the answer.
                  y_s     = A;
                  state_s = FIN;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            w_s   = w_shl_s;
            cnt_s = cnt_r - cnt_one;
            // The last shift is taken straight into Y so completion costs
            // no extra cycle beyond the k shift edges.
            if (cnt_r == cnt_one) begin
               y_s     = w_shl_s;
               state_s = FIN;
            end else begin
               state_s = SHIFT;
            end
         end
         FIN: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            w_s     = {N{1'b0}};
            cnt_s   = cnt_zero;
            y_s     = y_r;
         end
      endcase
   end

   // State, work, counter and result registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= IDLE;
         w_r     <= {N{1'b0}};
         cnt_r   <= cnt_zero;
         y_r     <= {N{1'b0}};
      end else begin
         state_r <= state_s;
         w_r     <= w_s;
         cnt_r   <= cnt_s;
         y_r     <= y_s;
      end
   end

   // Status flags come straight off the state register: no input-to-output
   // combinational path.
   assign BUSY = (state_r == SHIFT);
   assign DONE = (state_r == FIN);
   assign Y    = y_r;

endmodule
